// File: rtl/pipe_elastic_reg.sv
// pipe_elastic_reg -- DEPTH-stage elastic pipeline register with flush and hold.
//
// Stage 0 is the input side and stage DEPTH-1 the output side. Each stage
// advances whenever it is empty or the stage below it can advance. This
// collapses bubbles even while the consumer stalls. in_ready depends only on
// stage state, out_ready and hold_i, so there is no path from in_valid or
// in_data to in_ready.
//
// Parameters:
//   DW       payload width (1..64)
//   DEPTH    number of register stages (1..8)
//   SET_DATA data loaded into every stage on reset and flush (NOP encoding)
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   flush_i                        drop every stage, reload SET_DATA
//   hold_i                         freeze every stage; in_ready and out_valid are forced to 0
//   in_valid/in_ready/in_data      upstream handshake
//   out_valid/out_ready/out_data   downstream handshake
//   occ_o                          number of valid stages (registered)
//   stall_cnt_o                    saturating count of output stall cycles,
//                                  present only when PIPE_ELASTIC_STATS_EN is defined
//
// Priority: rst > flush_i > hold_i > normal advance.

module pipe_elastic_reg #(
    parameter int              DW       = 32,
    parameter int              DEPTH    = 2,
    parameter logic [DW-1:0]   SET_DATA = DW'(32'h0000_0013)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_i,
    input  logic                         hold_i,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DW-1:0]                in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DW-1:0]                out_data,
    output logic [$clog2(DEPTH+1)-1:0]   occ_o
`ifdef PIPE_ELASTIC_STATS_EN
    ,
    output logic [31:0]                  stall_cnt_o
`endif
);

    localparam int OW = $clog2(DEPTH+1);

    logic [DEPTH-1:0] v;
    logic [DW-1:0]    d [DEPTH];
    logic [DEPTH:0]   rdy;
    logic [DEPTH-1:0] v_n;
    logic [OW-1:0]    occ_n;
    logic             acc;

    // Advance chain. The running OR keeps the chain free of a
    // self-referencing vector.
    always_comb begin
        acc        = out_ready & ~hold_i;
        rdy[DEPTH] = acc;
        for (int k = DEPTH-1; k >= 0; k--) begin
            acc    = acc | ~v[k];
            rdy[k] = acc;
        end
    end

    assign in_ready  = rdy[0] & ~hold_i;
    assign out_valid = v[DEPTH-1] & ~hold_i;
    assign out_data  = d[DEPTH-1];

    // Next valid bits and occupancy. Hold does not need to be handled here
    // because the register block ignores these values during hold.
    always_comb begin
        v_n = v;
        if (rdy[0])
            v_n[0] = in_valid;
        for (int k = 1; k < DEPTH; k++) begin
            if (rdy[k])
                v_n[k] = v[k-1];
        end
        occ_n = '0;
        for (int k = 0; k < DEPTH; k++)
            occ_n = occ_n + OW'(v_n[k]);
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            v     <= '0;
            occ_o <= '0;
            for (int k = 0; k < DEPTH; k++)
                d[k] <= SET_DATA;
        end else if (!hold_i) begin
            v     <= v_n;
            occ_o <= occ_n;
            // Data moves only with a valid word. A bubble leaves the old data
            // in place, so the data registers do not toggle on bubbles.
            if (rdy[0] && in_valid)
                d[0] <= in_data;
            for (int k = 1; k < DEPTH; k++) begin
                if (rdy[k] && v[k-1])
                    d[k] <= d[k-1];
            end
        end
    end

`ifdef PIPE_ELASTIC_STATS_EN
    // Counts cycles where the output holds a word that the consumer refuses.
    // Hold cycles are not counted. Flush does not clear the counter.
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt_o <= '0;
        else if (v[DEPTH-1] && !out_ready && !hold_i && stall_cnt_o != 32'hFFFF_FFFF)
            stall_cnt_o <= stall_cnt_o + 32'd1;
    end
`endif

endmodule

// File: tb/tb_pipe_elastic_reg.sv
// Directed bench for pipe_elastic_reg. Two instances (DEPTH=2 and DEPTH=3)
// share the same stimulus, and each scenario checks the instance it targets.
// Inputs change 1 time unit after a rising edge, and outputs are sampled
// 1 time unit after that.

module tb_pipe_elastic_reg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, flush_i, hold_i, in_valid, out_ready;
    logic [31:0] in_data;

    logic        in_ready2, out_valid2, in_ready3, out_valid3;
    logic [31:0] out_data2, out_data3;
    logic [1:0]  occ2, occ3;
`ifdef PIPE_ELASTIC_STATS_EN
    logic [31:0] stall2, stall3;
`endif

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipe_elastic_reg #(.DW(32), .DEPTH(2)) u_d2 (
        .clk(clk), .rst(rst), .flush_i(flush_i), .hold_i(hold_i),
        .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .occ_o(occ2)
`ifdef PIPE_ELASTIC_STATS_EN
        , .stall_cnt_o(stall2)
`endif
    );

    pipe_elastic_reg #(.DW(32), .DEPTH(3)) u_d3 (
        .clk(clk), .rst(rst), .flush_i(flush_i), .hold_i(hold_i),
        .in_valid(in_valid), .in_ready(in_ready3), .in_data(in_data),
        .out_valid(out_valid3), .out_ready(out_ready), .out_data(out_data3),
        .occ_o(occ3)
`ifdef PIPE_ELASTIC_STATS_EN
        , .stall_cnt_o(stall3)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; flush_i = 1'b0; hold_i = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        tick;
        rst = 1'b0;
    endtask

    // Push three words into the stalled DEPTH=3 pipe so that it is full.
    task automatic fill3(input logic [31:0] base);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = base + 32'(i);
            tick;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        // reset state
        do_reset;
        tick;
        #1;
        chk("rst_occ2",  32'(occ2), 0);
        chk("rst_ov2",   32'(out_valid2), 0);
        chk("rst_od2",   out_data2, NOP);
        chk("rst_occ3",  32'(occ3), 0);
        chk("rst_od3",   out_data3, NOP);
        chk("rst_ir3",   32'(in_ready3), 1);

        // DEPTH=2 streaming at one word per cycle, latency of 2 cycles
        do_reset;
        out_ready = 1'b1; in_valid = 1'b1;
        in_data = 32'h11; #1 chk("s_ir0", 32'(in_ready2), 1); tick;
        in_data = 32'h22; #1 chk("s_ir1", 32'(in_ready2), 1); tick;
        in_data = 32'h33; #1 chk("s_ov2", 32'(out_valid2), 1); chk("s_od2", out_data2, 32'h11); tick;
        in_valid = 1'b0;  #1 chk("s_ov3", 32'(out_valid2), 1); chk("s_od3", out_data2, 32'h22); tick;
        #1 chk("s_ov4", 32'(out_valid2), 1); chk("s_od4", out_data2, 32'h33); tick;
        #1 chk("s_ov5", 32'(out_valid2), 0);

        // DEPTH=3 backpressure: 3 of 4 words accepted, then release
        do_reset;
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 32'hA1; #1 chk("bp_ir0", 32'(in_ready3), 1); tick;
        in_data = 32'hA2; #1 chk("bp_ir1", 32'(in_ready3), 1); tick;
        in_data = 32'hA3; #1 chk("bp_ir2", 32'(in_ready3), 1); tick;
        in_data = 32'hA4; #1
        chk("bp_ir3",  32'(in_ready3), 0);
        chk("bp_occ",  32'(occ3), 3);
        chk("bp_ov",   32'(out_valid3), 1);
        chk("bp_od",   out_data3, 32'hA1);
        out_ready = 1'b1; #1
        chk("bp_ir3r", 32'(in_ready3), 1);
        tick;
        in_valid = 1'b0;
        #1 chk("bp_o2", out_data3, 32'hA2); chk("bp_v2", 32'(out_valid3), 1); tick;
        #1 chk("bp_o3", out_data3, 32'hA3); chk("bp_v3", 32'(out_valid3), 1); tick;
        #1 chk("bp_o4", out_data3, 32'hA4); chk("bp_v4", 32'(out_valid3), 1); tick;
        #1 chk("bp_end", 32'(out_valid3), 0);

        // flush drops two in-flight words and the word offered during flush
        do_reset;
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 32'hB1; tick;
        in_data = 32'hB2; tick;
        #1 chk("fl_occ_pre", 32'(occ3), 2);
        flush_i = 1'b1; in_data = 32'hBF; tick;
        flush_i = 1'b0; in_valid = 1'b0;
        #1
        chk("fl_occ", 32'(occ3), 0);
        chk("fl_ov",  32'(out_valid3), 0);
        chk("fl_od",  out_data3, NOP);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 chk("fl_gone", 32'(out_valid3), 0);
            tick;
        end

        // hold for 5 cycles freezes everything, then flow resumes
        do_reset;
        out_ready = 1'b1; in_valid = 1'b1;
        in_data = 32'hC1; tick;
        in_data = 32'hC2; tick;
        hold_i = 1'b1; in_data = 32'hC3;
        for (int i = 0; i < 5; i++) begin
            #1
            chk("hd_ir",  32'(in_ready3), 0);
            chk("hd_ov",  32'(out_valid3), 0);
            chk("hd_occ", 32'(occ3), 2);
            chk("hd_od",  out_data3, NOP);
            tick;
        end
        hold_i = 1'b0;
        #1 chk("hd_ir_rel", 32'(in_ready3), 1); tick;
        in_valid = 1'b0;
        #1 chk("hd_o1", out_data3, 32'hC1); chk("hd_v1", 32'(out_valid3), 1); tick;
        #1 chk("hd_o2", out_data3, 32'hC2); chk("hd_v2", 32'(out_valid3), 1); tick;
        #1 chk("hd_o3", out_data3, 32'hC3); chk("hd_v3", 32'(out_valid3), 1); tick;
        #1 chk("hd_end", 32'(out_valid3), 0);

        // flush and hold in the same cycle: flush wins
        do_reset;
        fill3(32'hD1);
        #1 chk("fh_pre", out_data3, 32'hD1);
        flush_i = 1'b1; hold_i = 1'b1; tick;
        flush_i = 1'b0; hold_i = 1'b0;
        #1
        chk("fh_occ", 32'(occ3), 0);
        chk("fh_od",  out_data3, NOP);
        chk("fh_ov",  32'(out_valid3), 0);

        // reset and flush in the same cycle: reset values
        fill3(32'hE1);
        #1 chk("rf_pre", 32'(occ3), 3);
        rst = 1'b1; flush_i = 1'b1; tick;
        rst = 1'b0; flush_i = 1'b0;
        #1
        chk("rf_occ", 32'(occ3), 0);
        chk("rf_od",  out_data3, NOP);
        chk("rf_ov",  32'(out_valid3), 0);

`ifdef PIPE_ELASTIC_STATS_EN
        // A word reaches the output after 3 cycles, then 7 stall cycles
        // follow, 2 of them under hold. Only the 5 unheld cycles count.
        do_reset;
        #1 chk("st_rst", stall3, 0);
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hF1; tick;
        in_valid = 1'b0; tick; tick;
        #1 chk("st_arr", 32'(out_valid3), 1);
        for (int i = 0; i < 7; i++) begin
            hold_i = (i == 2 || i == 3);
            tick;
        end
        hold_i = 1'b0;
        #1 chk("st_cnt", stall3, 5);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
